// File: rtl/dual_issue_scoreboard_if.sv
// Issue/writeback bundle between the ID-stage fetch buffer and the dual-issue scoreboard.
// The master side presents instruction pairs and writebacks; the slave side returns grants and status.
interface dual_issue_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
);
    localparam int IDX_W = $clog2(NREG);
    localparam int OUT_W = $clog2(NREG + 1);

    logic             flush;
    logic             stall_in;

    logic             valid_1;
    logic [IDX_W-1:0] rs1_1;
    logic [IDX_W-1:0] rs2_1;
    logic [IDX_W-1:0] rd_1;
    logic             reg_write_1;

    logic             valid_2;
    logic [IDX_W-1:0] rs1_2;
    logic [IDX_W-1:0] rs2_2;
    logic [IDX_W-1:0] rd_2;
    logic             reg_write_2;

    logic             wb_valid_1;
    logic [IDX_W-1:0] wb_rd_1;
    logic             wb_valid_2;
    logic [IDX_W-1:0] wb_rd_2;

    logic             issue_1;
    logic             issue_2;
    logic [NREG-1:0]  busy_mask;
    logic [OUT_W-1:0] outstanding;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output flush, stall_in,
        output valid_1, rs1_1, rs2_1, rd_1, reg_write_1,
        output valid_2, rs1_2, rs2_2, rd_2, reg_write_2,
        output wb_valid_1, wb_rd_1, wb_valid_2, wb_rd_2,
        input  issue_1, issue_2, busy_mask, outstanding, stall_cycles
    );

    modport slave (
        input  flush, stall_in,
        input  valid_1, rs1_1, rs2_1, rd_1, reg_write_1,
        input  valid_2, rs1_2, rs2_2, rd_2, reg_write_2,
        input  wb_valid_1, wb_rd_1, wb_valid_2, wb_rd_2,
        output issue_1, issue_2, busy_mask, outstanding, stall_cycles
    );
endinterface

// File: rtl/dual_issue_scoreboard.sv
// In-order dual-issue hazard scoreboard: one busy bit per architectural register, grants
// instruction pairs free of RAW/WAW hazards and releases busy bits from two writeback ports.
module dual_issue_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input logic                    clk,
    input logic                    rst,
    dual_issue_scoreboard_if.slave sb
);
    localparam int IDX_W = $clog2(NREG);
    localparam int OUT_W = $clog2(NREG + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [NREG-1:0]  mask_t;

    mask_t            busy_q;
    mask_t            busy_d;
    mask_t            set_vec;
    mask_t            clr_vec;
    logic [OUT_W-1:0] outstanding_q;
    logic [OUT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] stall_q;

    logic hz_1;
    logic hz_2;
    logic raw_pair;
    logic waw_pair;
    logic grant_1;
    logic grant_2;
    logic stall_inc;

    // Register 0 is hardwired zero and can never be busy.
    function automatic logic reg_busy(input mask_t m, input idx_t idx);
        return (idx != '0) && m[idx];
    endfunction

    // Hazards look only at the registered mask; same-cycle writebacks are not bypassed.
    always_comb begin
        hz_1 = reg_busy(busy_q, sb.rs1_1) || reg_busy(busy_q, sb.rs2_1)
            || (sb.reg_write_1 && reg_busy(busy_q, sb.rd_1));

        raw_pair = sb.reg_write_1 && (sb.rd_1 != '0)
                && ((sb.rs1_2 == sb.rd_1) || (sb.rs2_2 == sb.rd_1));
        waw_pair = sb.reg_write_1 && sb.reg_write_2
                && (sb.rd_1 == sb.rd_2) && (sb.rd_1 != '0);

        hz_2 = reg_busy(busy_q, sb.rs1_2) || reg_busy(busy_q, sb.rs2_2)
            || (sb.reg_write_2 && reg_busy(busy_q, sb.rd_2))
            || raw_pair || waw_pair;

        grant_1   = sb.valid_1 && !hz_1 && !sb.stall_in && !sb.flush && !rst;
        grant_2   = grant_1 && sb.valid_2 && !hz_2;
        stall_inc = sb.valid_1 && hz_1 && !sb.stall_in && !sb.flush;
    end

    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;

        if (sb.wb_valid_1 && (sb.wb_rd_1 != '0)) clr_vec[sb.wb_rd_1] = 1'b1;
        if (sb.wb_valid_2 && (sb.wb_rd_2 != '0)) clr_vec[sb.wb_rd_2] = 1'b1;

        if (grant_1 && sb.reg_write_1 && (sb.rd_1 != '0)) set_vec[sb.rd_1] = 1'b1;
        if (grant_2 && sb.reg_write_2 && (sb.rd_2 != '0)) set_vec[sb.rd_2] = 1'b1;

        // Set is applied after clear so a colliding issue keeps the register busy; flush beats both.
        busy_d    = sb.flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
        busy_d[0] = 1'b0;

        outstanding_d = '0;
        for (int i = 1; i < NREG; i++) begin
            outstanding_d = outstanding_d + OUT_W'(busy_d[i]);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            stall_q       <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign sb.issue_1      = grant_1;
    assign sb.issue_2      = grant_2;
    assign sb.busy_mask    = busy_q;
    assign sb.outstanding  = outstanding_q;
    assign sb.stall_cycles = stall_q;
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed and randomized bench for dual_issue_scoreboard; every cycle is compared against a
// register-array reference model built from the hazard, set/clear and counter rules.
module tb_dual_issue_scoreboard;
    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int IDX_W = 5;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    dual_issue_scoreboard_if #(.NREG(NREG), .CNT_W(CNT_W)) bus ();

    dual_issue_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference state: one flag per register plus an integer stall counter.
    bit mbusy [NREG];
    int mstall = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush = 1'b0;        bus.stall_in = 1'b0;
        bus.valid_1 = 1'b0;      bus.rs1_1 = '0; bus.rs2_1 = '0; bus.rd_1 = '0; bus.reg_write_1 = 1'b0;
        bus.valid_2 = 1'b0;      bus.rs1_2 = '0; bus.rs2_2 = '0; bus.rd_2 = '0; bus.reg_write_2 = 1'b0;
        bus.wb_valid_1 = 1'b0;   bus.wb_rd_1 = '0;
        bus.wb_valid_2 = 1'b0;   bus.wb_rd_2 = '0;
    endtask

    task automatic slot1(input int v, input int a, input int b, input int d, input int w);
        bus.valid_1 = 1'(v); bus.rs1_1 = IDX_W'(a); bus.rs2_1 = IDX_W'(b);
        bus.rd_1 = IDX_W'(d); bus.reg_write_1 = 1'(w);
    endtask

    task automatic slot2(input int v, input int a, input int b, input int d, input int w);
        bus.valid_2 = 1'(v); bus.rs1_2 = IDX_W'(a); bus.rs2_2 = IDX_W'(b);
        bus.rd_2 = IDX_W'(d); bus.reg_write_2 = 1'(w);
    endtask

    task automatic wb(input int v1, input int r1, input int v2, input int r2);
        bus.wb_valid_1 = 1'(v1); bus.wb_rd_1 = IDX_W'(r1);
        bus.wb_valid_2 = 1'(v2); bus.wb_rd_2 = IDX_W'(r2);
    endtask

    function automatic bit mb(input logic [IDX_W-1:0] r);
        return (r != '0) && mbusy[r];
    endfunction

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m = '0;
        for (int i = 0; i < NREG; i++) m[i] = mbusy[i];
        return m;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    // One clock: check grants against the rules, advance the model, then check registered state.
    task automatic cycle();
        bit h1, h2, e1, e2, inc;
        bit nb [NREG];
        #1;
        h1 = mb(bus.rs1_1) || mb(bus.rs2_1) || (bus.reg_write_1 && mb(bus.rd_1));
        h2 = mb(bus.rs1_2) || mb(bus.rs2_2) || (bus.reg_write_2 && mb(bus.rd_2))
          || (bus.reg_write_1 && bus.rd_1 != '0 && (bus.rs1_2 == bus.rd_1 || bus.rs2_2 == bus.rd_1))
          || (bus.reg_write_1 && bus.reg_write_2 && bus.rd_1 == bus.rd_2 && bus.rd_1 != '0);
        e1 = bus.valid_1 && !h1 && !bus.stall_in && !bus.flush && !rst;
        e2 = e1 && bus.valid_2 && !h2;
        check("issue_1", 64'(bus.issue_1), 64'(e1));
        check("issue_2", 64'(bus.issue_2), 64'(e2));

        inc = bus.valid_1 && h1 && !bus.stall_in && !bus.flush;
        nb  = mbusy;
        if (rst) begin
            foreach (nb[i]) nb[i] = 1'b0;
            mstall = 0;
        end else begin
            if (inc && mstall < SAT) mstall++;
            if (bus.flush) begin
                foreach (nb[i]) nb[i] = 1'b0;
            end else begin
                if (bus.wb_valid_1 && bus.wb_rd_1 != '0) nb[bus.wb_rd_1] = 1'b0;
                if (bus.wb_valid_2 && bus.wb_rd_2 != '0) nb[bus.wb_rd_2] = 1'b0;
                if (e1 && bus.reg_write_1 && bus.rd_1 != '0) nb[bus.rd_1] = 1'b1;
                if (e2 && bus.reg_write_2 && bus.rd_2 != '0) nb[bus.rd_2] = 1'b1;
            end
        end
        mbusy = nb;

        @(posedge clk);
        #1;
        check("busy_mask",    64'(bus.busy_mask),    64'(model_mask()));
        check("outstanding",  64'(bus.outstanding),  64'(model_count()));
        check("stall_cycles", 64'(bus.stall_cycles), 64'(mstall));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        phase = "reset";
        slot1(1, 3, 0, 5, 1);
        cycle();
        cycle();
        check("reset_mask", 64'(bus.busy_mask), 64'h0);
        check("reset_stall", 64'(bus.stall_cycles), 64'h0);

        rst = 1'b0;
        phase = "first_issue";
        cycle();
        check("mask_0x20", 64'(bus.busy_mask), 64'h20);
        check("outstanding_1", 64'(bus.outstanding), 64'd1);

        phase = "raw_hold";
        idle(); slot1(1, 0, 5, 6, 1); slot2(1, 1, 2, 9, 1);
        repeat (3) cycle();
        check("stall_3", 64'(bus.stall_cycles), 64'd3);
        phase = "raw_wb_no_bypass";
        wb(1, 5, 0, 0);
        cycle();
        phase = "raw_release";
        wb(0, 0, 0, 0);
        cycle();
        check("mask_6_9", 64'(bus.busy_mask), 64'h240);

        phase = "pair_raw";
        idle(); slot1(1, 0, 0, 7, 1); slot2(1, 7, 0, 10, 1);
        cycle();
        idle(); wb(1, 6, 1, 9); cycle();
        idle(); wb(1, 7, 0, 0); cycle();
        phase = "pair_waw";
        idle(); slot1(1, 0, 0, 7, 1); slot2(1, 0, 0, 7, 1);
        cycle();
        idle(); wb(1, 7, 0, 0); cycle();
        phase = "pair_ok";
        idle(); slot1(1, 3, 4, 7, 1); slot2(1, 1, 2, 8, 1);
        cycle();
        check("mask_7_8", 64'(bus.busy_mask), 64'h180);
        check("outstanding_2", 64'(bus.outstanding), 64'd2);

        phase = "reg_zero";
        idle(); slot1(1, 0, 0, 0, 1); slot2(1, 0, 0, 0, 1); wb(1, 7, 1, 8);
        cycle();
        idle(); wb(1, 0, 0, 0);
        cycle();
        check("mask_zero", 64'(bus.busy_mask), 64'h0);

        phase = "dual_wb";
        idle(); slot1(1, 0, 0, 4, 1); slot2(1, 0, 0, 9, 1);
        cycle();
        check("mask_4_9", 64'(bus.busy_mask), 64'h210);
        idle(); wb(1, 4, 1, 9);
        cycle();
        check("dual_wb_outstanding", 64'(bus.outstanding), 64'd0);

        phase = "flush";
        idle(); slot1(1, 0, 0, 12, 1);
        cycle();
        idle(); bus.flush = 1'b1; slot1(1, 0, 0, 13, 1);
        cycle();
        check("flush_mask", 64'(bus.busy_mask), 64'h0);

        phase = "set_wins";
        idle(); slot1(1, 0, 0, 10, 1); wb(1, 10, 0, 0);
        cycle();
        check("mask_10", 64'(bus.busy_mask), 64'h400);
        idle(); wb(0, 0, 1, 10);
        cycle();

        phase = "stall_in";
        idle(); bus.stall_in = 1'b1; slot1(1, 0, 0, 3, 1);
        cycle();
        check("stall_held", 64'(bus.stall_cycles), 64'd4);

        phase = "saturate";
        idle(); slot1(1, 0, 0, 5, 1);
        cycle();
        slot1(1, 5, 0, 6, 1);
        repeat (20) cycle();
        check("stall_sat", 64'(bus.stall_cycles), 64'(SAT));
        phase = "same_reg_wb";
        idle(); wb(1, 5, 1, 5);
        cycle();

        phase = "mid_reset";
        idle(); slot1(1, 0, 0, 11, 1); slot2(1, 0, 0, 12, 1);
        cycle();
        rst = 1'b1; slot1(1, 0, 0, 14, 1);
        cycle();
        rst = 1'b0; idle(); wb(1, 11, 1, 12);
        cycle();
        check("post_reset_mask", 64'(bus.busy_mask), 64'h0);

        phase = "random";
        for (int n = 0; n < 400; n++) begin
            idle();
            slot1(int'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                  int'($urandom_range(7, 0)), int'($urandom_range(1, 0)));
            slot2(int'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                  int'($urandom_range(7, 0)), int'($urandom_range(1, 0)));
            wb(int'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
               int'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
            bus.stall_in = ($urandom_range(7, 0) == 0);
            bus.flush    = ($urandom_range(29, 0) == 0);
            rst          = ($urandom_range(99, 0) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_issue_scoreboard.md
Name: dual_issue_scoreboard

Overview:
In-order dual-issue hazard scoreboard in the ID stage, beside the two-read/two-write register file. Tracks one busy bit per architectural register for writes that have issued but not yet written back. Grants issue to slot 1 and slot 2 only when no RAW or WAW hazard exists against in-flight writes or within the pair. Clears busy bits from the two writeback ports.

Parameters:
NREG, 32, number of architectural registers; index 0 is hardwired zero.
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  pipeline flush; clears all busy bits
stall_in  input  1  downstream ID/EX stall; no grants while high
valid_1  input  1  slot-1 instruction present
rs1_1, rs2_1  input  5  slot-1 source indices; 0 means unused
rd_1  input  5  slot-1 destination
reg_write_1  input  1  slot-1 writes rd_1
valid_2, rs1_2, rs2_2, rd_2, reg_write_2  input  1/5/5/5/1  same fields for slot 2 (younger)
wb_valid_1  input  1  writeback port 1 retires a write
wb_rd_1  input  5  writeback port 1 destination
wb_valid_2  input  1  writeback port 2 retires a write
wb_rd_2  input  5  writeback port 2 destination
issue_1  output  1  slot 1 granted this cycle (combinational)
issue_2  output  1  slot 2 granted this cycle (combinational)
busy_mask  output  32  registered busy bits; bit 0 always 0
outstanding  output  6  registered popcount of busy_mask
stall_cycles  output  CNT_W  registered count of cycles in which slot 1 was hazard-blocked

Behaviour:
- Reset (rst=1 at edge): busy_mask=0, outstanding=0, stall_cycles=0. issue_1 and issue_2 are 0 while rst=1.
- Hazard checks use only the registered busy_mask. A same-cycle writeback clear is not bypassed into the check.
- hz_1: any nonzero rs1_1/rs2_1 is busy, or reg_write_1 with nonzero rd_1 that is busy (WAW).
- issue_1 = valid_1 & ~hz_1 & ~stall_in & ~flush & ~rst.
- hz_2: same busy checks for slot 2, plus intra-pair hazards:
  - nonzero rs1_2 or rs2_2 equals rd_1 while reg_write_1 (RAW);
  - reg_write_1 & reg_write_2 & rd_1==rd_2 & rd_1≠0 (WAW).
- issue_2 = issue_1 & valid_2 & ~hz_2. Strict in-order: slot 2 never issues alone. If slot 1 is granted and slot 2 is not, slot 2 is re-presented as slot 1 by the fetch buffer.
- Set on edge: issue_k & reg_write_k & rd_k≠0 sets busy[rd_k].
- Clear on edge: wb_valid_k & wb_rd_k≠0 clears busy[wb_rd_k]. Both ports may clear the same or different registers in one cycle.
- Set and clear hitting the same register in one cycle: set wins. This is unreachable when the upstream contract holds, but must be implemented.
- Writeback to a non-busy register: no effect, no error.
- flush=1: busy_mask←0 next edge, overriding all sets and clears. Grants are 0 that cycle. stall_cycles is unaffected.
- outstanding is the popcount of the next busy_mask value, updated on the same edge (0..31).
- stall_cycles increments by 1 when valid_1 & hz_1 & ~stall_in & ~flush. It saturates at all-ones.
- Reset mid-operation drops all busy state. In-flight writebacks arriving after reset are harmless no-ops.
- Latency: grant is combinational in the request cycle. Busy visibility appears 1 cycle after issue; release appears 1 cycle after writeback.

Test Plan:
- Reset then idle: busy_mask=0, outstanding=0, stall_cycles=0. valid_1=1, rs1_1=3, rd_1=5, reg_write_1=1 → issue_1=1; next cycle busy_mask=0x20, outstanding=1.
- RAW across cycles: busy[5]=1, slot 1 reads rs2_1=5 → issue_1=0, issue_2=0, stall_cycles+1 per cycle. wb_valid_1=1, wb_rd_1=5 → next cycle issue_1=1.
- Intra-pair: slot 1 has rd_1=7, reg_write_1=1; slot 2 reads rs1_2=7 → issue_1=1, issue_2=0. Repeat with rd_2=7 (WAW) → issue_2=0. With rd_2=8 and sources independent → issue_2=1; busy bits 7 and 8 set.
- Register 0: rd_1=0 with reg_write_1=1 and rs1_2=0 → both granted, busy_mask stays 0. wb_rd_1=0 → no change.
- Dual writeback with flush: busy[4]=1, busy[9]=1; wb_rd_1=4 and wb_rd_2=9 in one cycle → busy_mask=0, outstanding=0. Set busy[12], then flush=1 with a same-cycle issue to rd 13 → busy_mask=0, issue_1=0.
- stall_in=1 with a hazard-free slot 1 → no grants, stall_cycles unchanged. Preload stall_cycles near all-ones under a persistent hazard → saturates, no wrap.
